// File: rtl/pia_pkg.sv
// Shared definitions for the Apple-1 PIA blocks: bus addresses, handshake
// state encodings and status bit positions.
package pia_pkg;

  localparam logic [15:0] KBD_ADDR_C   = 16'hD010;
  localparam logic [15:0] KBDCR_ADDR_C = 16'hD011;
  localparam logic [15:0] DSP_ADDR_C   = 16'hD012;
  localparam logic [15:0] DSPCR_ADDR_C = 16'hD013;

  // One-hot handshake states; any other encoding recovers to S_WAIT.
  typedef enum logic [1:0] {
    S_WAIT = 2'b01,
    S_ACK  = 2'b10
  } kbd_state_e;

  localparam int STAT_RDY = 7;
  localparam int STAT_OVF = 6;

endpackage

// File: rtl/pia_sync_fifo.sv
// Single-clock FIFO with occupancy count. When empty, dout holds the most
// recently popped entry so a repeated read of an empty queue returns the
// last keystroke, like the original single-register port.
module pia_sync_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  last;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? last : mem[rd_ptr];

  // Pointer, count and last-popped bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents only matter once written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pia_kbd_fifo.sv
// Apple-1 PIA keyboard port with a receive FIFO behind KBD/KBDCR.
// Optional macro PIA_KBD_DROP_EN: keystrokes arriving while the FIFO is full
// are acked and discarded with a sticky overflow flag, instead of being held
// off by backpressure.
// Handshake: the keyboard holds kbd_rdy with kbd_data stable until it sees
// kbd_ack high, then drops kbd_rdy; kbd_ack falls once kbd_rdy is low.
module pia_kbd_fifo
  import pia_pkg::*;
#(
  parameter int          DATA_W     = 7,
  parameter int          DEPTH      = 4,
  parameter logic [15:0] KBD_ADDR   = KBD_ADDR_C,
  parameter logic [15:0] KBDCR_ADDR = KBDCR_ADDR_C,
  localparam int         CW         = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       Address_Bus,
  input  logic              WE,
  output logic [7:0]        Data_Out,
  input  logic              kbd_rdy,
  output logic              kbd_ack,
  input  logic [DATA_W-1:0] kbd_data,
  output logic              kbd_ovf
);

  kbd_state_e        state;
  kbd_state_e        state_n;
  logic              ack_n;
  logic              load;
  logic              done;
  logic              accept;
  logic [DATA_W-1:0] hold;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic [CW-1:0]     count;
  logic              ovf;

  logic              rsel_kbd;
  logic              rsel_cr;
  logic              wr_cr;
  logic              rd_q;
  logic [7:0]        kbd_byte;
  logic [7:0]        kbd_latch;
  logic [7:0]        cr_byte;

  assign rsel_kbd = (Address_Bus == KBD_ADDR) && !WE;
  assign rsel_cr  = (Address_Bus == KBDCR_ADDR) && !WE;
  assign wr_cr    = (Address_Bus == KBDCR_ADDR) && WE;
  assign pop      = rsel_kbd && !rd_q;

`ifdef PIA_KBD_DROP_EN
  assign accept = 1'b1;
  assign push   = done && !full;

  // Sticky overflow: set when a completed keystroke finds the FIFO full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else begin
      if (wr_cr) ovf <= 1'b0;
      if (done && full) ovf <= 1'b1;
    end
  end
`else
  assign accept = !full;
  assign push   = done;
  assign ovf    = 1'b0;
`endif

  assign kbd_ovf = ovf;

  // Handshake next-state and registered-ack decode.
  always_comb begin
    state_n = state;
    ack_n   = 1'b0;
    load    = 1'b0;
    done    = 1'b0;
    case (state)
      S_WAIT: begin
        if (kbd_rdy && accept) begin
          state_n = S_ACK;
          ack_n   = 1'b1;
          load    = 1'b1;
        end
      end
      S_ACK: begin
        ack_n = 1'b1;
        if (!kbd_rdy) begin
          state_n = S_WAIT;
          ack_n   = 1'b0;
          done    = 1'b1;
        end
      end
      default: state_n = S_WAIT;
    endcase
  end

  // Handshake state, ack output and captured keystroke.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_WAIT;
      kbd_ack <= 1'b0;
      hold    <= '0;
    end else begin
      state   <= state_n;
      kbd_ack <= ack_n;
      if (load) hold <= kbd_data;
    end
  end

  pia_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (hold),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Read-access tracking; the byte seen at the pop is held for the whole access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q      <= 1'b0;
      kbd_latch <= 8'h00;
    end else begin
      rd_q <= rsel_kbd;
      if (pop) kbd_latch <= kbd_byte;
    end
  end

  // Status bytes and the read-data mux.
  always_comb begin
    kbd_byte           = {1'b0, 7'(head)};
    kbd_byte[STAT_RDY] = !empty;
    cr_byte            = {3'b000, 5'(count)};
    cr_byte[STAT_RDY]  = !empty;
    cr_byte[STAT_OVF]  = ovf;
    Data_Out           = 8'h00;
    if (rsel_kbd)     Data_Out = rd_q ? kbd_latch : kbd_byte;
    else if (rsel_cr) Data_Out = cr_byte;
  end

endmodule

// File: tb/tb_pia_kbd_fifo.sv
// Directed bench for pia_kbd_fifo: stimulus tasks queue expected values,
// a negedge monitor pops and compares them against the observed outputs.
module tb_pia_kbd_fifo;

  localparam logic [15:0] KBD   = 16'hD010;
  localparam logic [15:0] KBDCR = 16'hD011;
  localparam logic [9:0]  M_DATA = 10'h0FF;
  localparam logic [9:0]  M_ACK  = 10'h100;
  localparam logic [9:0]  M_OVF  = 10'h200;
  localparam logic [9:0]  M_ALL  = 10'h3FF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] Address_Bus = 16'h0000;
  logic        WE = 1'b0;
  logic [7:0]  Data_Out;
  logic        kbd_rdy = 1'b0;
  logic        kbd_ack;
  logic [6:0]  kbd_data = 7'h00;
  logic        kbd_ovf;

  logic [9:0]  exp_q[$];
  logic [9:0]  msk_q[$];
  string       name_q[$];
  logic        probe_valid = 1'b0;
  int          tests = 0;
  int          fails = 0;

  pia_kbd_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .Address_Bus (Address_Bus),
    .WE          (WE),
    .Data_Out    (Data_Out),
    .kbd_rdy     (kbd_rdy),
    .kbd_ack     (kbd_ack),
    .kbd_data    (kbd_data),
    .kbd_ovf     (kbd_ovf)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Monitor / scoreboard: compare observed {ovf, ack, Data_Out} under mask.
  always @(negedge clk) begin
    if (probe_valid) begin
      logic [9:0] obs, e, m;
      string      nm;
      obs = {kbd_ovf, kbd_ack, Data_Out};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard: got %h with no expected entry required one", obs);
      end else begin
        e  = exp_q.pop_front();
        m  = msk_q.pop_front();
        nm = name_q.pop_front();
        if ((obs & m) !== (e & m)) begin
          fails++;
          $display("FAIL %s: got %h required %h (mask %h)", nm, obs & m, e & m, m);
        end
      end
    end
  end

  // Driver tasks; all are entered and left just after a rising edge,
  // except chk which returns just after the following falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [9:0] m, input logic [9:0] e);
    exp_q.push_back(e);
    msk_q.push_back(m);
    name_q.push_back(nm);
    probe_valid = 1'b1;
    @(negedge clk);
    #1;
    probe_valid = 1'b0;
  endtask

  task automatic wait_ack(input logic lvl, input int budget);
    int n = 0;
    while (kbd_ack !== lvl && n < budget) begin
      cycle();
      n++;
    end
  endtask

  task automatic send_key(input logic [6:0] d);
    kbd_data = d;
    kbd_rdy  = 1'b1;
    wait_ack(1'b1, 8);
    chk("ack_rise", M_ACK, 10'h100);
    cycle();
    kbd_rdy = 1'b0;
    wait_ack(1'b0, 8);
    chk("ack_fall", M_ACK, 10'h000);
    cycle();
  endtask

  task automatic rd(input string nm, input logic [15:0] a, input logic [7:0] e);
    Address_Bus = a;
    WE = 1'b0;
    chk(nm, M_DATA, {2'b00, e});
    cycle();
    Address_Bus = 16'h0000;
    cycle();
  endtask

  task automatic wr(input logic [15:0] a);
    Address_Bus = a;
    WE = 1'b1;
    cycle();
    WE = 1'b0;
    Address_Bus = 16'h0000;
    cycle();
  endtask

  task automatic fill_abcd();
    send_key(7'h41);
    send_key(7'h42);
    send_key(7'h43);
    send_key(7'h44);
  endtask

  initial begin
    // Reset
    reset = 1'b0;
    cycle();
    chk("reset_outputs", M_ALL, 10'h000);
    cycle();
    reset = 1'b1;
    cycle();
    rd("reset_kbdcr", KBDCR, 8'h00);

    // 1: single key, then re-read of the empty queue
    send_key(7'h41);
    rd("t1_first_read", KBD, 8'hC1);
    rd("t1_second_read", KBD, 8'h41);
    rd("t1_kbdcr", KBDCR, 8'h00);

    // 2: burst of four keys, drained in order
    fill_abcd();
    rd("t2_kbdcr_full", KBDCR, 8'h84);
    rd("t2_read_a", KBD, 8'hC1);
    rd("t2_read_b", KBD, 8'hC2);
    rd("t2_read_c", KBD, 8'hC3);
    rd("t2_read_d", KBD, 8'hC4);
    rd("t2_kbdcr_empty", KBDCR, 8'h00);

`ifdef PIA_KBD_DROP_EN
    // 4: fifth key is acked and dropped, overflow flagged
    fill_abcd();
    send_key(7'h45);
    Address_Bus = KBDCR;
    chk("t4_kbdcr_ovf", M_ALL, {1'b1, 1'b0, 8'hC4});
    cycle();
    Address_Bus = 16'h0000;
    cycle();
    wr(KBDCR);
    Address_Bus = KBDCR;
    chk("t4_ovf_cleared", M_ALL, {1'b0, 1'b0, 8'h84});
    cycle();
    Address_Bus = 16'h0000;
    cycle();
    rd("t4_read_a", KBD, 8'hC1);
    rd("t4_read_b", KBD, 8'hC2);
    rd("t4_read_c", KBD, 8'hC3);
    rd("t4_read_d", KBD, 8'hC4);
    rd("t4_kbdcr_empty", KBDCR, 8'h00);
`else
    // 3: fifth key held off while full, accepted after one read
    fill_abcd();
    kbd_data = 7'h45;
    kbd_rdy  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_ack_held_low", M_ALL, 10'h000);
      cycle();
    end
    rd("t3_kbdcr_full", KBDCR, 8'h84);
    rd("t3_read_a", KBD, 8'hC1);
    wait_ack(1'b1, 2);
    chk("t3_ack_after_pop", M_ACK, 10'h100);
    cycle();
    kbd_rdy = 1'b0;
    wait_ack(1'b0, 8);
    chk("t3_ack_fall", M_ACK, 10'h000);
    cycle();
    rd("t3_read_b", KBD, 8'hC2);
    rd("t3_read_c", KBD, 8'hC3);
    rd("t3_read_d", KBD, 8'hC4);
    rd("t3_read_e", KBD, 8'hC5);
    rd("t3_kbdcr_empty", KBDCR, 8'h00);
`endif

    // 5: held read address pops once; push and pop in the same cycle
    send_key(7'h41);
    send_key(7'h42);
    send_key(7'h43);
    Address_Bus = KBD;
    WE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_held_read", M_DATA, {2'b00, 8'hC1});
      cycle();
    end
    Address_Bus = 16'h0000;
    cycle();
    rd("t5_count_after_hold", KBDCR, 8'h82);
    kbd_data = 7'h44;
    kbd_rdy  = 1'b1;
    wait_ack(1'b1, 8);
    chk("t5_ack_rise", M_ACK, 10'h100);
    cycle();
    kbd_rdy = 1'b0;
    Address_Bus = KBD;
    chk("t5_pop_with_push", M_ALL, {2'b01, 8'hC2});
    cycle();
    Address_Bus = 16'h0000;
    chk("t5_ack_fall", M_ACK, 10'h000);
    cycle();
    rd("t5_count_unchanged", KBDCR, 8'h82);
    rd("t5_read_c", KBD, 8'hC3);
    rd("t5_read_d", KBD, 8'hC4);
    rd("t5_kbdcr_empty", KBDCR, 8'h00);

    // 6: reset during S_ACK, then the keyboard re-presents
    send_key(7'h41);
    kbd_data = 7'h42;
    kbd_rdy  = 1'b1;
    wait_ack(1'b1, 8);
    chk("t6_ack_before_reset", M_ACK, 10'h100);
    cycle();
    Address_Bus = KBDCR;
    #1;
    reset = 1'b0;
    chk("t6_async_reset", M_ALL, 10'h000);
    cycle();
    Address_Bus = KBD;
    chk("t6_kbd_in_reset", M_ALL, 10'h000);
    reset = 1'b1;
    Address_Bus = 16'h0000;
    cycle();
    wait_ack(1'b1, 8);
    chk("t6_reack", M_ACK, 10'h100);
    cycle();
    kbd_rdy = 1'b0;
    wait_ack(1'b0, 8);
    chk("t6_ack_fall", M_ACK, 10'h000);
    cycle();
    rd("t6_read_b", KBD, 8'hC2);
    rd("t6_kbdcr_empty", KBDCR, 8'h00);

    // Report
    cycle();
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
